// File: rtl/l2_tag_ctrl.sv
// rtl/l2_tag_ctrl.sv - L2 tag store sequencer/arbiter for two L1 miss requesters (optional macro L2_INVALID_FIRST_EN)
module l2_tag_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ic_req,
    input  logic [25:0] ic_addr,
    output logic        ic_ack,
    input  logic        dc_req,
    input  logic        dc_wr,
    input  logic [25:0] dc_addr,
    output logic        dc_ack,
    output logic        rsp_hit,
    output logic [1:0]  rsp_way,
    output logic [8:0]  l2_index,
    output logic [17:0] l2_tag_wd,
    output logic        l2_dirty_wd,
    output logic        l2_block0_rw,
    output logic        l2_block1_rw,
    output logic        l2_block2_rw,
    output logic        l2_block3_rw,
    input  logic [17:0] l2_tag0_rd,
    input  logic [17:0] l2_tag1_rd,
    input  logic [17:0] l2_tag2_rd,
    input  logic [17:0] l2_tag3_rd,
    input  logic        l2_dirty0,
    input  logic        l2_dirty1,
    input  logic        l2_dirty2,
    input  logic        l2_dirty3,
    input  logic [2:0]  plru,
    output logic        miss_req,
    output logic [1:0]  miss_way,
    output logic [8:0]  miss_index,
    output logic        miss_wb,
    output logic [16:0] miss_wb_tag,
    input  logic        fill_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMPARE,
        S_MISS,
        S_UPDATE,
        S_ACK
    } state_t;

    state_t      state_q;
    logic        last_dc_q;
    logic        src_dc_q;
    logic        wr_q;
    logic [16:0] tag_q;
    logic        hit_q;
    logic [1:0]  way_q;

    logic        ic_ack_q;
    logic        dc_ack_q;
    logic        rsp_hit_q;
    logic [1:0]  rsp_way_q;
    logic [8:0]  l2_index_q;
    logic [17:0] l2_tag_wd_q;
    logic        l2_dirty_wd_q;
    logic [3:0]  block_rw_q;
    logic        miss_req_q;
    logic [1:0]  miss_way_q;
    logic [8:0]  miss_index_q;
    logic        miss_wb_q;
    logic [16:0] miss_wb_tag_q;

    logic [17:0] tag_rd [4];
    logic [3:0]  dirty_rd;
    logic [3:0]  hit_vec;
    logic        hit_any;
    logic [1:0]  hit_way;
    logic [1:0]  plru_way;
    logic [1:0]  victim_way;
    logic        grant_dc;
    logic [25:0] grant_addr;

    // Round-robin grant: when both request, the source not granted last wins
    always_comb begin
        grant_dc   = dc_req & (~ic_req | ~last_dc_q);
        grant_addr = grant_dc ? dc_addr : ic_addr;
    end

    // Hit detection, lowest-way priority, and victim selection from RAM read data
    always_comb begin
        tag_rd[0] = l2_tag0_rd;
        tag_rd[1] = l2_tag1_rd;
        tag_rd[2] = l2_tag2_rd;
        tag_rd[3] = l2_tag3_rd;
        dirty_rd  = {l2_dirty3, l2_dirty2, l2_dirty1, l2_dirty0};
        hit_vec   = '0;
        hit_way   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            hit_vec[i] = tag_rd[i][17] & (tag_rd[i][16:0] == tag_q);
        end
        for (int i = 3; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = 2'(i);
        end
        hit_any  = |hit_vec;
        plru_way = plru[0] ? (plru[2] ? 2'd3 : 2'd2) : (plru[1] ? 2'd1 : 2'd0);
`ifdef L2_INVALID_FIRST_EN
        victim_way = plru_way;
        for (int i = 3; i >= 0; i--) begin
            if (!tag_rd[i][17]) victim_way = 2'(i);
        end
`else
        victim_way = plru_way;
`endif
    end

    // Sequencer with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            last_dc_q     <= 1'b1;
            src_dc_q      <= 1'b0;
            wr_q          <= 1'b0;
            tag_q         <= '0;
            hit_q         <= 1'b0;
            way_q         <= '0;
            ic_ack_q      <= 1'b0;
            dc_ack_q      <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_way_q     <= '0;
            l2_index_q    <= '0;
            l2_tag_wd_q   <= '0;
            l2_dirty_wd_q <= 1'b0;
            block_rw_q    <= '0;
            miss_req_q    <= 1'b0;
            miss_way_q    <= '0;
            miss_index_q  <= '0;
            miss_wb_q     <= 1'b0;
            miss_wb_tag_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ic_req | dc_req) begin
                        src_dc_q   <= grant_dc;
                        wr_q       <= grant_dc & dc_wr;
                        tag_q      <= grant_addr[25:9];
                        l2_index_q <= grant_addr[8:0];
                        state_q    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state_q <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (hit_any) begin
                        hit_q         <= 1'b1;
                        way_q         <= hit_way;
                        block_rw_q    <= 4'b0001 << hit_way;
                        l2_tag_wd_q   <= {1'b1, tag_q};
                        l2_dirty_wd_q <= dirty_rd[hit_way] | wr_q;
                        state_q       <= S_UPDATE;
                    end else begin
                        hit_q         <= 1'b0;
                        way_q         <= victim_way;
                        miss_req_q    <= 1'b1;
                        miss_way_q    <= victim_way;
                        miss_index_q  <= l2_index_q;
                        miss_wb_q     <= tag_rd[victim_way][17] & dirty_rd[victim_way];
                        miss_wb_tag_q <= tag_rd[victim_way][16:0];
                        state_q       <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (fill_done) begin
                        miss_req_q    <= 1'b0;
                        block_rw_q    <= 4'b0001 << way_q;
                        l2_tag_wd_q   <= {1'b1, tag_q};
                        l2_dirty_wd_q <= wr_q;
                        state_q       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    block_rw_q    <= '0;
                    l2_tag_wd_q   <= '0;
                    l2_dirty_wd_q <= 1'b0;
                    rsp_hit_q     <= hit_q;
                    rsp_way_q     <= way_q;
                    ic_ack_q      <= ~src_dc_q;
                    dc_ack_q      <= src_dc_q;
                    state_q       <= S_ACK;
                end
                S_ACK: begin
                    ic_ack_q  <= 1'b0;
                    dc_ack_q  <= 1'b0;
                    rsp_hit_q <= 1'b0;
                    rsp_way_q <= '0;
                    last_dc_q <= src_dc_q;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ic_ack       = ic_ack_q;
    assign dc_ack       = dc_ack_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_way      = rsp_way_q;
    assign l2_index     = l2_index_q;
    assign l2_tag_wd    = l2_tag_wd_q;
    assign l2_dirty_wd  = l2_dirty_wd_q;
    assign l2_block0_rw = block_rw_q[0];
    assign l2_block1_rw = block_rw_q[1];
    assign l2_block2_rw = block_rw_q[2];
    assign l2_block3_rw = block_rw_q[3];
    assign miss_req     = miss_req_q;
    assign miss_way     = miss_way_q;
    assign miss_index   = miss_index_q;
    assign miss_wb      = miss_wb_q;
    assign miss_wb_tag  = miss_wb_tag_q;

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// tb/tb_l2_tag_ctrl.sv - directed self-checking bench for l2_tag_ctrl
module tb_l2_tag_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req, dc_req, dc_wr, fill_done;
    logic [25:0] ic_addr, dc_addr;
    logic        ic_ack, dc_ack, rsp_hit;
    logic [1:0]  rsp_way, miss_way;
    logic [8:0]  l2_index, miss_index;
    logic [17:0] l2_tag_wd;
    logic        l2_dirty_wd;
    logic        l2_block0_rw, l2_block1_rw, l2_block2_rw, l2_block3_rw;
    logic [17:0] l2_tag0_rd, l2_tag1_rd, l2_tag2_rd, l2_tag3_rd;
    logic        l2_dirty0, l2_dirty1, l2_dirty2, l2_dirty3;
    logic [2:0]  plru;
    logic        miss_req, miss_wb;
    logic [16:0] miss_wb_tag;
    logic [3:0]  strb;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  exp_way;
    logic        exp_wb;
    logic [16:0] exp_wb_tag;

    localparam logic [25:0] ADDR_AB = {17'h000AB, 9'h005};

    always #5 clk = ~clk;

    assign strb = {l2_block3_rw, l2_block2_rw, l2_block1_rw, l2_block0_rw};

    l2_tag_ctrl dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_ack(dc_ack),
        .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .l2_index(l2_index), .l2_tag_wd(l2_tag_wd), .l2_dirty_wd(l2_dirty_wd),
        .l2_block0_rw(l2_block0_rw), .l2_block1_rw(l2_block1_rw),
        .l2_block2_rw(l2_block2_rw), .l2_block3_rw(l2_block3_rw),
        .l2_tag0_rd(l2_tag0_rd), .l2_tag1_rd(l2_tag1_rd),
        .l2_tag2_rd(l2_tag2_rd), .l2_tag3_rd(l2_tag3_rd),
        .l2_dirty0(l2_dirty0), .l2_dirty1(l2_dirty1),
        .l2_dirty2(l2_dirty2), .l2_dirty3(l2_dirty3),
        .plru(plru),
        .miss_req(miss_req), .miss_way(miss_way), .miss_index(miss_index),
        .miss_wb(miss_wb), .miss_wb_tag(miss_wb_tag),
        .fill_done(fill_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tags(input logic [17:0] t0, input logic [17:0] t1,
                            input logic [17:0] t2, input logic [17:0] t3,
                            input logic [3:0] d, input logic [2:0] p);
        l2_tag0_rd = t0; l2_tag1_rd = t1; l2_tag2_rd = t2; l2_tag3_rd = t3;
        {l2_dirty3, l2_dirty2, l2_dirty1, l2_dirty0} = d;
        plru = p;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        ic_req = 0; dc_req = 0; dc_wr = 0; fill_done = 0;
        ic_addr = '0; dc_addr = '0;
        set_tags(18'h0, 18'h0, 18'h0, 18'h0, 4'b0000, 3'b000);
        #1;
        do_reset();

        // reset state
        check("rst_ic_ack", ic_ack, 0);
        check("rst_miss_req", miss_req, 0);
        check("rst_strb", strb, 0);
        check("rst_index", l2_index, 0);
        check("rst_tag_wd", l2_tag_wd, 0);

        // 1: cold miss, fill at cycle 5
        ic_addr = ADDR_AB;
        ic_req  = 1;
        step();
        check("t1_lookup_index", l2_index, 9'h005);
        check("t1_lookup_strb", strb, 0);
        step();
        step();
        check("t1_miss_req", miss_req, 1);
        check("t1_miss_way", miss_way, 0);
        check("t1_miss_wb", miss_wb, 0);
        check("t1_miss_index", miss_index, 9'h005);
        step();
        check("t1_miss_strb", strb, 0);
        step();
        fill_done = 1;
        step();
        fill_done = 0;
        check("t1_upd_strb", strb, 4'b0001);
        check("t1_upd_tag_wd", l2_tag_wd, 18'h200AB);
        check("t1_upd_miss_req", miss_req, 0);
        check("t1_upd_index", l2_index, 9'h005);
        step();
        check("t1_ic_ack", ic_ack, 1);
        check("t1_rsp_hit", rsp_hit, 0);
        check("t1_rsp_way", rsp_way, 0);
        check("t1_ack_strb", strb, 0);
        ic_req = 0;
        step();
        check("t1_ack_pulse", ic_ack, 0);

        // 2: hit in way0, stray fill_done ignored
        set_tags(18'h200AB, 18'h0, 18'h0, 18'h0, 4'b0000, 3'b000);
        ic_req = 1;
        step();
        fill_done = 1;
        step();
        fill_done = 0;
        step();
        check("t2_upd_strb", strb, 4'b0001);
        check("t2_no_miss", miss_req, 0);
        check("t2_dirty_wd", l2_dirty_wd, 0);
        step();
        check("t2_ic_ack", ic_ack, 1);
        check("t2_rsp_hit", rsp_hit, 1);
        check("t2_rsp_way", rsp_way, 0);
        ic_req = 0;
        step();

        // 3: round-robin from reset, I-cache first, 4 transactions
        do_reset();
        dc_addr = ADDR_AB;
        ic_req = 1;
        dc_req = 1;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 4 || k == 14) begin
                check($sformatf("t3_ic_ack_c%0d", k), ic_ack, 1);
                check($sformatf("t3_dc_idle_c%0d", k), dc_ack, 0);
            end
            if (k == 9 || k == 19) begin
                check($sformatf("t3_dc_ack_c%0d", k), dc_ack, 1);
                check($sformatf("t3_ic_idle_c%0d", k), ic_ack, 0);
            end
            if (k == 5) check("t3_ack_one_cycle", ic_ack, 0);
        end
        ic_req = 0;
        dc_req = 0;
        step();

        // 4: D-cache write hit in way2, old dirty 0
        set_tags(18'h0, 18'h0, 18'h200AB, 18'h0, 4'b0000, 3'b000);
        dc_wr  = 1;
        dc_req = 1;
        step();
        step();
        step();
        check("t4_upd_strb", strb, 4'b0100);
        check("t4_dirty_wd", l2_dirty_wd, 1);
        check("t4_tag_wd", l2_tag_wd, 18'h200AB);
        step();
        check("t4_dc_ack", dc_ack, 1);
        check("t4_ic_ack", ic_ack, 0);
        check("t4_rsp_hit", rsp_hit, 1);
        check("t4_rsp_way", rsp_way, 2);
        dc_req = 0;
        step();

        // 5: victim selection, way3 invalid; I-cache grant ignores dc_wr; earliest fill
        set_tags(18'h20001, 18'h20002, 18'h20003, 18'h00004, 4'b0010, 3'b010);
`ifdef L2_INVALID_FIRST_EN
        exp_way = 2'd3; exp_wb = 1'b0; exp_wb_tag = 17'h00004;
`else
        exp_way = 2'd1; exp_wb = 1'b1; exp_wb_tag = 17'h00002;
`endif
        dc_wr  = 1;
        ic_req = 1;
        step();
        step();
        step();
        check("t5_miss_req", miss_req, 1);
        check("t5_miss_way", miss_way, exp_way);
        check("t5_miss_wb", miss_wb, exp_wb);
        check("t5_miss_wb_tag", miss_wb_tag, exp_wb_tag);
        fill_done = 1;
        step();
        fill_done = 0;
        check("t5_upd_strb", strb, 4'b0001 << exp_way);
        check("t5_dirty_wd", l2_dirty_wd, 0);
        step();
        check("t5_ic_ack", ic_ack, 1);
        check("t5_rsp_hit", rsp_hit, 0);
        check("t5_rsp_way", rsp_way, exp_way);
        ic_req = 0;
        dc_wr  = 0;
        step();

        // 6: reset asserted while in MISS, then a normal request
        ic_req = 1;
        step();
        step();
        step();
        step();
        check("t6_in_miss", miss_req, 1);
        #1;
        reset = 0;
        #1;
        check("t6_rst_miss_req", miss_req, 0);
        check("t6_rst_strb", strb, 0);
        check("t6_rst_index", l2_index, 0);
        check("t6_rst_wb", miss_wb, 0);
        ic_req = 0;
        step();
        step();
        reset = 1;
        set_tags(18'h200AB, 18'h0, 18'h0, 18'h0, 4'b0000, 3'b000);
        ic_req = 1;
        step();
        step();
        step();
        check("t6_post_strb", strb, 4'b0001);
        step();
        check("t6_post_ack", ic_ack, 1);
        check("t6_post_hit", rsp_hit, 1);
        ic_req = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
